// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM-to-PCM decimator: width derivation, warm-up states, input map.
package pdm_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Two integrator stages of log2(R) growth each, plus sign and the +R^2 headroom bit.
  function automatic int acc_w(input int decim);
    return 2 * clog2(decim) + 2;
  endfunction

  function automatic int pcm_shift(input int decim, input int out_w);
    return out_w - 1 - 2 * clog2(decim);
  endfunction

  typedef enum logic [1:0] {
    WARM0,
    WARM1,
    RUN
  } warm_e;

  localparam int X_POS = 1;
  localparam int X_NEG = -1;

endpackage

// File: rtl/pdm_salida_hs.sv
// Single-entry valid/ready output register; a sample arriving while full is dropped
// and latches a sticky overrun flag (a drop beats a simultaneous clear).
module pdm_salida_hs #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         smp_vld_i,
  input  logic [W-1:0] smp_dat_i,
  input  logic         out_rdy_i,
  input  logic         clr_ovr_i,
  output logic [W-1:0] out_dat_o,
  output logic         out_vld_o,
  output logic         ovr_o
);

  logic         vld_q, vld_d;
  logic         ovr_q, ovr_d;
  logic [W-1:0] dat_q, dat_d;
  logic         load, drop;

  always_comb begin
    load  = smp_vld_i & (~vld_q | out_rdy_i);
    drop  = smp_vld_i & vld_q & ~out_rdy_i;
    dat_d = load ? smp_dat_i : dat_q;
    vld_d = load | (vld_q & ~out_rdy_i);
    ovr_d = drop | (ovr_q & ~clr_ovr_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      dat_q <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      ovr_q <= ovr_d;
      dat_q <= dat_d;
    end
  end

  assign out_dat_o = dat_q;
  assign out_vld_o = vld_q;
  assign ovr_o     = ovr_q;

endmodule

// File: rtl/pdm_decimador.sv
// 2nd-order CIC decimator turning a strobed 1-bit PDM stream into signed PCM.
// Sample is valid 2 clk after the frame-end strobe; output register drops on overrun.
module pdm_decimador
  import pdm_pkg::*;
#(
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             pdm_bit,
  input  logic             pdm_en,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int L     = clog2(DECIM);
  localparam int ACC_W = acc_w(DECIM);
  localparam int SHIFT = pcm_shift(DECIM, OUT_W);
  localparam logic [ACC_W-1:0] FULL_SCALE = ACC_W'(DECIM * DECIM);
  localparam logic [2*L:0]     MAX_POS    = (2*L+1)'(DECIM * DECIM - 1);
  localparam logic [L-1:0]     LAST_PHASE = L'(DECIM - 1);

  if (DECIM < 4 || (DECIM & (DECIM - 1)) != 0 || 2 * L > OUT_W - 1) begin : g_bad_param
    $error("pdm_decimador: DECIM must be a power of two in [4, 2**((OUT_W-1)/2)]");
  end

  logic [ACC_W-1:0] i1_q, i2_q, d1_q, d2_q;
  logic [ACC_W-1:0] x, i1_d, i2_d, c1_d, c2_d;
  logic [L-1:0]     phase_q;
  logic             frame_q;
  warm_e            warm_q;
  logic             smp_vld_q;
  logic [OUT_W-1:0] smp_q, pcm_d;
  logic [2*L:0]     sat_d;
  logic             accept;

  assign accept = run & pdm_en;
  assign x      = pdm_bit ? ACC_W'(X_POS) : ACC_W'(X_NEG);
  assign i1_d   = i1_q + x;
  assign i2_d   = i2_q + i1_d;
  assign c1_d   = i2_q - d1_q;
  assign c2_d   = c1_d - d2_q;
  // Only +R^2 overflows the signed output range; -R^2 maps exactly to full negative scale.
  assign sat_d  = (c2_d == FULL_SCALE) ? MAX_POS : c2_d[2*L:0];
  assign pcm_d  = OUT_W'(sat_d) << SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q    <= '0;
      i2_q    <= '0;
      phase_q <= '0;
      frame_q <= 1'b0;
    end else if (!run) begin
      i1_q    <= '0;
      i2_q    <= '0;
      phase_q <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= accept && (phase_q == LAST_PHASE);
      if (accept) begin
        i1_q    <= i1_d;
        i2_q    <= i2_d;
        phase_q <= phase_q + L'(1);
      end
    end
  end

  // Comb stage and warm-up FSM: the first two comb results only prime the delays.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_q      <= '0;
      d2_q      <= '0;
      warm_q    <= WARM0;
      smp_vld_q <= 1'b0;
      smp_q     <= '0;
    end else if (!run) begin
      d1_q      <= '0;
      d2_q      <= '0;
      warm_q    <= WARM0;
      smp_vld_q <= 1'b0;
      smp_q     <= '0;
    end else begin
      smp_vld_q <= 1'b0;
      if (frame_q) begin
        d1_q <= i2_q;
        d2_q <= c1_d;
        case (warm_q)
          WARM0: warm_q <= WARM1;
          WARM1: warm_q <= RUN;
          RUN: begin
            smp_vld_q <= 1'b1;
            smp_q     <= pcm_d;
          end
          default: warm_q <= WARM0;
        endcase
      end
    end
  end

  pdm_salida_hs #(
    .W(OUT_W)
  ) u_salida (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (!run),
    .smp_vld_i (smp_vld_q),
    .smp_dat_i (smp_q),
    .out_rdy_i (pcm_ready),
    .clr_ovr_i (clr_ovr),
    .out_dat_o (pcm_data),
    .out_vld_o (pcm_valid),
    .ovr_o     (overrun)
  );

endmodule

// File: tb/tb_pdm_decimador.sv
// Bench for pdm_decimador: pattern table, output-register corner sequences, random vs CIC model.
module tb_pdm_decimador;

  localparam int DECIM = 64;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             reset, run, pdm_bit, pdm_en, pcm_ready, clr_ovr;
  logic [OUT_W-1:0] pcm_data;
  logic             pcm_valid, overrun;

  always #5 clk = ~clk;

  pdm_decimador #(
    .DECIM(DECIM),
    .OUT_W(OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .pdm_bit   (pdm_bit),
    .pdm_en    (pdm_en),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bitn = 0;
  int got_cyc[$];
  logic [15:0] got_dat[$];
  int fe_cyc[$];

  typedef struct {
    int          pat;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pat_bit(input int pat, input int idx);
    case (pat)
      0: return 1'b1;
      1: return 1'b0;
      2: return (idx % 2) == 0;
      3: return (idx % 4) == 0;
      4: return (idx % 4) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pcm_valid) begin
      got_cyc.push_back(cyc);
      got_dat.push_back(pcm_data);
    end
  endtask

  task automatic clear_log();
    got_cyc.delete();
    got_dat.delete();
    fe_cyc.delete();
    bitn = 0;
  endtask

  task automatic feed(input int pat, input int n);
    for (int i = 0; i < n; i++) begin
      pdm_en  = 1'b1;
      pdm_bit = pat_bit(pat, bitn);
      tick();
      bitn++;
      if (bitn % DECIM == 0) fe_cyc.push_back(cyc);
    end
    pdm_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic flush();
    run     = 1'b0;
    pdm_en  = 1'b0;
    clr_ovr = 1'b0;
    tick();
    run = 1'b1;
    clear_log();
  endtask

  task automatic restart_test(input bit use_reset);
    flush();
    pcm_ready = 1'b0;
    feed(0, 4 * DECIM + 30);
    chk("pre_stop_overrun", 32'(overrun), 32'd1);
    if (use_reset) begin
      reset = 1'b1;
    end else begin
      run     = 1'b0;
      pdm_en  = 1'b1;
      pdm_bit = 1'b1;
    end
    tick();
    chk(use_reset ? "rst_valid" : "stop_valid", 32'(pcm_valid), 32'd0);
    chk(use_reset ? "rst_data" : "stop_data", 32'(pcm_data), 32'd0);
    chk(use_reset ? "rst_overrun" : "stop_overrun", 32'(overrun), 32'd0);
    reset     = 1'b0;
    run       = 1'b1;
    pdm_en    = 1'b0;
    pcm_ready = 1'b1;
    clear_log();
    feed(0, 2 * DECIM);
    idle(4);
    chk("restart_warmup_silent", 32'(got_cyc.size()), 32'd0);
    feed(0, DECIM);
    idle(3);
    chk("restart_count", 32'(got_cyc.size()), 32'd1);
    if (got_cyc.size() >= 1 && fe_cyc.size() >= 3) begin
      chk("restart_data", 32'(got_dat[0]), 32'h7FF8);
      chk("restart_latency", 32'(got_cyc[0] - fe_cyc[2]), 32'd2);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    longint      s1, s2, c2;
    longint      fe[$];
    int          nb, dens, k;
    bit          en, b, ev, st1_v, st2_v, exp_v;
    logic [15:0] evd, st1_d, st2_d, exp_d;

    reset = 1'b1; run = 1'b0; pdm_bit = 1'b0; pdm_en = 1'b0;
    pcm_ready = 1'b1; clr_ovr = 1'b0;
    idle(2);
    chk("reset_valid", 32'(pcm_valid), 32'd0);
    chk("reset_data", 32'(pcm_data), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    run   = 1'b1;

    // Steady-state second difference equals mean(x) * R^2, scaled by 8.
    vecs[0] = '{pat: 0, exp: 16'h7FF8};
    vecs[1] = '{pat: 1, exp: 16'h8000};
    vecs[2] = '{pat: 2, exp: 16'h0000};
    vecs[3] = '{pat: 3, exp: 16'hC000};
    vecs[4] = '{pat: 4, exp: 16'h4000};
    for (int v = 0; v < 5; v++) begin
      flush();
      pcm_ready = 1'b1;
      feed(vecs[v].pat, 4 * DECIM);
      idle(3);
      chk($sformatf("vec%0d_count", v), 32'(got_cyc.size()), 32'd2);
      for (int s = 0; s < 2 && s < got_cyc.size(); s++) begin
        chk($sformatf("vec%0d_data%0d", v, s), 32'(got_dat[s]), 32'(vecs[v].exp));
        chk($sformatf("vec%0d_latency%0d", v, s), 32'(got_cyc[s] - fe_cyc[s + 2]), 32'd2);
      end
      chk($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
    end

    // Held output, overrun, clear, clear-vs-drop, single transfer.
    flush();
    pcm_ready = 1'b0;
    feed(0, 3 * DECIM);
    feed(1, DECIM);
    idle(2);
    chk("hold_valid", 32'(pcm_valid), 32'd1);
    chk("hold_data", 32'(pcm_data), 32'h7FF8);
    chk("hold_overrun", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);
    feed(0, DECIM);
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_vs_drop_overrun", 32'(overrun), 32'd1);
    chk("clr_vs_drop_data", 32'(pcm_data), 32'h7FF8);
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;
    chk("consume_valid", 32'(pcm_valid), 32'd0);
    chk("consume_data_hold", 32'(pcm_data), 32'h7FF8);

    // Consume in the same clock a new sample arrives: replace, no overrun.
    flush();
    pcm_ready = 1'b0;
    feed(0, 3 * DECIM);
    feed(1, DECIM);
    tick();
    chk("replace_before_data", 32'(pcm_data), 32'h7FF8);
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;
    chk("replace_valid", 32'(pcm_valid), 32'd1);
    chk("replace_data", 32'(pcm_data), 32'hFE00);
    chk("replace_overrun", 32'(overrun), 32'd0);

    restart_test(1'b1);
    restart_test(1'b0);

    // Random stream against a double running-sum model (unbounded integers).
    flush();
    pcm_ready = 1'b1;
    s1 = 0; s2 = 0; nb = 0; dens = 50;
    fe.delete();
    fe.push_back(0);
    st1_v = 1'b0; st2_v = 1'b0; st1_d = '0; st2_d = '0; evd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) dens = $urandom_range(0, 100);
      en = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 99) < dens);
      pdm_en  = en;
      pdm_bit = b;
      ev = 1'b0;
      if (en) begin
        s1 = s1 + (b ? 1 : -1);
        s2 = s2 + s1;
        nb++;
        if (nb % DECIM == 0) begin
          fe.push_back(s2);
          k = fe.size() - 1;
          if (k >= 3) begin
            c2 = fe[k] - 2 * fe[k-1] + fe[k-2];
            if (c2 > DECIM * DECIM - 1) c2 = DECIM * DECIM - 1;
            ev  = 1'b1;
            evd = 16'(c2 * 8);
          end
        end
      end
      tick();
      exp_v = st2_v;
      exp_d = st2_d;
      st2_v = st1_v;
      st2_d = st1_d;
      st1_v = ev;
      st1_d = evd;
      chk("rnd_valid", 32'(pcm_valid), 32'(exp_v));
      if (exp_v) chk("rnd_data", 32'(pcm_data), 32'(exp_d));
    end
    pdm_en = 1'b0;
    chk("rnd_overrun", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
